// File: rtl/spinner_quad_gen.sv
// Spinner/paddle quadrature generator: mouse, dpad, analog and USB-spinner inputs are
// turned into a signed step budget that is drained as A/B quadrature, with ext_enc passthrough.
module spinner_quad_gen #(
    parameter int CHANNELS  = 1,
    parameter int POS_W     = 12,
    parameter int STEP_DIV  = 1500,
    parameter int POLL_DIV  = 48000,
    parameter int DPAD_SLOW = 4,
    parameter int DPAD_FAST = 9
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [CHANNELS-1:0]   delta_stb,
    input  logic [CHANNELS*9-1:0] delta,
    input  logic [CHANNELS-1:0]   btn_left,
    input  logic [CHANNELS-1:0]   btn_right,
    input  logic [CHANNELS-1:0]   btn_fast,
    input  logic [CHANNELS*8-1:0] analog_x,
    input  logic [1:0]            spin_res,
    input  logic [CHANNELS*2-1:0] ext_enc,
    output logic [CHANNELS*2-1:0] quad,
    output logic [CHANNELS-1:0]   ext_active,
    output logic [CHANNELS-1:0]   busy
);

    localparam int SW     = POS_W + 10;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int POLL_W = $clog2(POLL_DIV + 1);

    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [POLL_W-1:0]    POLL_LAST = POLL_W'(POLL_DIV - 1);
    localparam logic signed [SW-1:0] POS_MAX   = $signed({{(SW-POS_W+1){1'b0}}, {(POS_W-1){1'b1}}});
    localparam logic signed [SW-1:0] POS_MIN   = $signed({{(SW-POS_W+1){1'b1}}, {(POS_W-1){1'b0}}});

    typedef enum logic [1:0] {
        CODE_00 = 2'b00,
        CODE_01 = 2'b01,
        CODE_10 = 2'b10,
        CODE_11 = 2'b11
    } code_e;

    // Up: 11->01->00->10->11, down walks the same ring backwards.
    function automatic code_e code_step(input code_e c, input logic dn);
        case (c)
            CODE_11: return dn ? CODE_10 : CODE_01;
            CODE_01: return dn ? CODE_11 : CODE_00;
            CODE_00: return dn ? CODE_01 : CODE_10;
            default: return dn ? CODE_00 : CODE_11;
        endcase
    endfunction

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic signed [POS_W-1:0] pos_q, pos_d;
        code_e                   code_q, code_d;
        logic [STEP_W-1:0]       step_q, step_d;
        logic [POLL_W-1:0]       poll_q, poll_d;
        logic [1:0]              sync1_q, sync2_q;
        logic                    ext_act_q, ext_act_d;
        logic [1:0]              quad_q, quad_d;
        logic                    busy_q;

        logic signed [8:0]       dlt;
        logic signed [7:0]       ax, ax_sh;
        logic                    press, ax_on, poll_on, poll_hit, step_go, reload;
        logic [1:0]              shamt;
        logic signed [SW-1:0]    sum, spin_mag, dpad_mag;
        logic signed [POS_W-1:0] reload_v;

        always_comb begin
            dlt      = $signed(delta[ch*9 +: 9]);
            ax       = $signed(analog_x[ch*8 +: 8]);
            ax_sh    = ax >>> 4;
            press    = btn_left[ch] | btn_right[ch];
            ax_on    = (ax != '0);
            poll_on  = (spin_res == 2'd0) && (ax_on || press);
            poll_hit = ce && poll_on && (poll_q == POLL_LAST);
            step_go  = ce && (step_q == '0) && (pos_q != '0);

            step_d = step_q;
            if (ce) begin
                step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
            end

            poll_d = poll_q;
            if (!poll_on || poll_hit) begin
                poll_d = '0;
            end else if (ce) begin
                poll_d = poll_q + 1'b1;
            end

            code_d = step_go ? code_step(code_q, pos_q[POS_W-1]) : code_q;

            // Delta and step are combined before saturating so a step at the rail is not lost.
            sum = SW'(pos_q);
            if (delta_stb[ch]) begin
                sum = sum + SW'(dlt);
            end
            if (step_go) begin
                sum = pos_q[POS_W-1] ? sum + SW'(1) : sum - SW'(1);
            end

            shamt    = spin_res - {1'b0, ~btn_fast[ch]};
            spin_mag = SW'(2) << shamt;
            dpad_mag = btn_fast[ch] ? SW'(DPAD_FAST) : SW'(DPAD_SLOW);
            reload   = 1'b0;
            reload_v = '0;
            if (spin_res != 2'd0) begin
                if (ce && press) begin
                    reload   = 1'b1;
                    reload_v = POS_W'(btn_right[ch] ? spin_mag : -spin_mag);
                end
            end else if (poll_hit) begin
                reload = 1'b1;
                if (ax_on) begin
                    reload_v = (ax_sh == '0) ? POS_W'(1) : POS_W'(ax_sh);
                end else begin
                    reload_v = POS_W'(btn_right[ch] ? dpad_mag : -dpad_mag);
                end
            end

            if (reload) begin
                pos_d = reload_v;
            end else if (sum > POS_MAX) begin
                pos_d = POS_MAX[POS_W-1:0];
            end else if (sum < POS_MIN) begin
                pos_d = POS_MIN[POS_W-1:0];
            end else begin
                pos_d = sum[POS_W-1:0];
            end

            ext_act_d = ext_act_q;
            if (delta_stb[ch] || press || ax_on) begin
                ext_act_d = 1'b0;
            end else if (sync1_q != sync2_q) begin
                ext_act_d = 1'b1;
            end

            quad_d = ext_act_q ? sync2_q : code_q;
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                pos_q     <= '0;
                code_q    <= CODE_11;
                step_q    <= '0;
                poll_q    <= '0;
                sync1_q   <= 2'b11;
                sync2_q   <= 2'b11;
                ext_act_q <= 1'b0;
                quad_q    <= 2'b11;
                busy_q    <= 1'b0;
            end else begin
                pos_q     <= pos_d;
                code_q    <= code_d;
                step_q    <= step_d;
                poll_q    <= poll_d;
                sync1_q   <= ext_enc[ch*2 +: 2];
                sync2_q   <= sync1_q;
                ext_act_q <= ext_act_d;
                quad_q    <= quad_d;
                busy_q    <= (pos_d != '0);
            end
        end

        assign quad[ch*2 +: 2] = quad_q;
        assign ext_active[ch]  = ext_act_q;
        assign busy[ch]        = busy_q;
    end

endmodule

// File: tb/tb_spinner_quad_gen.sv
// Self-checking bench for spinner_quad_gen: directed scenarios plus randomized stimulus
// compared each cycle against an integer reference model of the channel behaviour.
module tb_spinner_quad_gen;

    localparam int CH = 2;
    localparam int PW = 12;
    localparam int SD = 8;
    localparam int PD = 20;
    localparam int DS = 4;
    localparam int DF = 9;
    localparam int PMAX = (1 << (PW - 1)) - 1;
    localparam int PMIN = -(1 << (PW - 1));

    logic            clk_sys = 1'b0;
    logic            reset = 1'b1;
    logic            ce = 1'b0;
    logic [CH-1:0]   delta_stb = '0;
    logic [CH*9-1:0] delta = '0;
    logic [CH-1:0]   btn_left = '0;
    logic [CH-1:0]   btn_right = '0;
    logic [CH-1:0]   btn_fast = '0;
    logic [CH*8-1:0] analog_x = '0;
    logic [1:0]      spin_res = '0;
    logic [CH*2-1:0] ext_enc = '1;
    logic [CH*2-1:0] quad;
    logic [CH-1:0]   ext_active;
    logic [CH-1:0]   busy;

    int errors = 0;
    int checks = 0;

    spinner_quad_gen #(
        .CHANNELS(CH), .POS_W(PW), .STEP_DIV(SD), .POLL_DIV(PD),
        .DPAD_SLOW(DS), .DPAD_FAST(DF)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .delta_stb(delta_stb), .delta(delta),
        .btn_left(btn_left), .btn_right(btn_right), .btn_fast(btn_fast),
        .analog_x(analog_x), .spin_res(spin_res), .ext_enc(ext_enc),
        .quad(quad), .ext_active(ext_active), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Ring position of a quadrature code: moving up the ring is a positive step.
    function automatic int ph_of(input logic [1:0] c);
        case (c)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] code_of(input int ph);
        case (ph)
            0:       return 2'b11;
            1:       return 2'b01;
            2:       return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    int         m_pos [CH];
    int         m_ph  [CH];
    int         m_step[CH];
    int         m_poll[CH];
    logic [1:0] m_s1  [CH];
    logic [1:0] m_s2  [CH];
    logic [1:0] m_quad[CH];
    bit         m_ext [CH];
    bit         m_busy[CH];

    initial begin : model
        int p, np, d, ax, mag;
        bit press, stb;
        forever begin
            @(posedge clk_sys or posedge reset);
            for (int c = 0; c < CH; c++) begin
                if (reset) begin
                    m_pos[c] = 0; m_ph[c] = 0; m_step[c] = 0; m_poll[c] = 0;
                    m_s1[c] = 2'b11; m_s2[c] = 2'b11; m_quad[c] = 2'b11;
                    m_ext[c] = 0; m_busy[c] = 0;
                end else begin
                    p     = m_pos[c];
                    d     = $signed(delta[c*9 +: 9]);
                    ax    = $signed(analog_x[c*8 +: 8]);
                    press = btn_left[c] | btn_right[c];
                    stb   = delta_stb[c];
                    m_quad[c] = m_ext[c] ? m_s2[c] : code_of(m_ph[c]);
                    np = p;
                    if (ce && m_step[c] == 0 && p != 0) begin
                        m_ph[c] = (p > 0) ? (m_ph[c] + 1) % 4 : (m_ph[c] + 3) % 4;
                        np = (p > 0) ? p - 1 : p + 1;
                    end
                    if (stb) np = np + d;
                    if (np > PMAX) np = PMAX;
                    if (np < PMIN) np = PMIN;
                    if (spin_res != 0) begin
                        m_poll[c] = 0;
                        if (ce && press) begin
                            mag = 2 << (int'(spin_res) - (btn_fast[c] ? 0 : 1));
                            np = btn_right[c] ? mag : -mag;
                        end
                    end else if (ax != 0 || press) begin
                        if (ce) begin
                            m_poll[c] = m_poll[c] + 1;
                            if (m_poll[c] == PD) begin
                                m_poll[c] = 0;
                                if (ax != 0) np = ((ax >>> 4) == 0) ? 1 : (ax >>> 4);
                                else begin
                                    mag = btn_fast[c] ? DF : DS;
                                    np = btn_right[c] ? mag : -mag;
                                end
                            end
                        end
                    end else begin
                        m_poll[c] = 0;
                    end
                    if (ce) m_step[c] = (m_step[c] + 1) % SD;
                    if (stb || press || ax != 0) m_ext[c] = 0;
                    else if (m_s1[c] != m_s2[c]) m_ext[c] = 1;
                    m_s2[c] = m_s1[c];
                    m_s1[c] = ext_enc[c*2 +: 2];
                    m_pos[c] = np;
                    m_busy[c] = (np != 0);
                end
            end
        end
    end

    task automatic idle_inputs();
        delta_stb = '0; delta = '0; btn_left = '0; btn_right = '0; btn_fast = '0;
        analog_x = '0; spin_res = '0; ext_enc = '1;
    endtask

    task automatic apply_reset();
        @(negedge clk_sys);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic pulse_delta(input int ch, input logic [8:0] val);
        delta_stb[ch] = 1'b1;
        delta[ch*9 +: 9] = val;
        @(negedge clk_sys);
        delta_stb[ch] = 1'b0;
        delta[ch*9 +: 9] = '0;
    endtask

    // Watches quad until busy has fallen and the final code has reached the output.
    task automatic count_steps(input int ch, input int budget, output int ps, output int ns,
                               output int gap_bad, output bit timeout);
        logic [1:0] prev, cur;
        int tail, last;
        prev = quad[ch*2 +: 2];
        ps = 0; ns = 0; gap_bad = 0; timeout = 1'b1; tail = -1; last = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            cur = quad[ch*2 +: 2];
            if (cur !== prev) begin
                if (ph_of(cur) == (ph_of(prev) + 1) % 4) ps++;
                else if (ph_of(cur) == (ph_of(prev) + 3) % 4) ns++;
                if (last >= 0 && i - last != SD) gap_bad++;
                last = i;
                prev = cur;
            end
            if (tail < 0 && busy[ch] == 1'b0) tail = 3;
            if (tail > 0) begin
                tail--;
                if (tail == 0) begin
                    timeout = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if ({quad[c*2 +: 2], busy[c], ext_active[c]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_hold ch%0d: got quad/busy/ext=%b required 1100", c,
                         {quad[c*2 +: 2], busy[c], ext_active[c]});
            end
        end
        reset = 1'b0;
        ce = 1'b1;
        repeat (4) @(negedge clk_sys);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if ({quad[c*2 +: 2], busy[c], ext_active[c]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_idle ch%0d: got quad/busy/ext=%b required 1100", c,
                         {quad[c*2 +: 2], busy[c], ext_active[c]});
            end
        end
    endtask

    task automatic test_delta_steps();
        int ps, ns, gb;
        bit to;
        apply_reset();
        ce = 1'b1;
        pulse_delta(0, 9'sd3);
        count_steps(0, 4 * SD + 20, ps, ns, gb, to);
        checks++;
        if (to || ps != 3 || ns != 0) begin
            errors++;
            $display("FAIL delta_plus3: got up=%0d down=%0d timeout=%0b required up=3 down=0 timeout=0", ps, ns, to);
        end
        checks++;
        if (gb != 0) begin
            errors++;
            $display("FAIL delta_spacing: got %0d gaps not equal %0d required 0", gb, SD);
        end
        checks++;
        if ({quad[1:0], busy[0]} !== 3'b100) begin
            errors++;
            $display("FAIL delta_end: got quad/busy=%b required 100", {quad[1:0], busy[0]});
        end
    endtask

    task automatic test_saturation();
        int ps, ns, gb;
        bit to;
        apply_reset();
        ce = 1'b1;
        pulse_delta(0, 9'h1FE);
        count_steps(0, 3 * SD + 20, ps, ns, gb, to);
        checks++;
        if (to || ps != 0 || ns != 2 || quad[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL delta_minus2: got up=%0d down=%0d quad=%b timeout=%0b required up=0 down=2 quad=00",
                     ps, ns, quad[1:0], to);
        end
        ce = 1'b0;
        delta_stb[0] = 1'b1;
        delta[8:0] = 9'h0FF;
        repeat (20) @(negedge clk_sys);
        delta[8:0] = 9'h101;
        repeat (8) @(negedge clk_sys);
        delta_stb[0] = 1'b0;
        delta[8:0] = '0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_busy: got busy=%b required 1", busy[0]);
        end
        ce = 1'b1;
        count_steps(0, 7 * SD + 30, ps, ns, gb, to);
        checks++;
        if (to || ps != 7 || ns != 0) begin
            errors++;
            $display("FAIL sat_residue: got up=%0d down=%0d timeout=%0b required up=7 down=0", ps, ns, to);
        end
    endtask

    task automatic test_dpad();
        int ps, ns, gb;
        bit to;
        apply_reset();
        ce = 1'b1;
        btn_right[0] = 1'b1;
        btn_fast[0] = 1'b1;
        repeat (PD - 1) @(negedge clk_sys);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL dpad_early: got busy=%b one ce before poll required 0", busy[0]);
        end
        @(negedge clk_sys);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL dpad_reload: got busy=%b at poll required 1", busy[0]);
        end
        btn_right[0] = 1'b0;
        btn_fast[0] = 1'b0;
        count_steps(0, 9 * SD + 30, ps, ns, gb, to);
        checks++;
        if (to || ps != 9 || ns != 0) begin
            errors++;
            $display("FAIL dpad_fast: got up=%0d down=%0d timeout=%0b required up=9 down=0", ps, ns, to);
        end
        apply_reset();
        ce = 1'b1;
        btn_left[0] = 1'b1;
        btn_right[0] = 1'b1;
        repeat (PD) @(negedge clk_sys);
        btn_left[0] = 1'b0;
        btn_right[0] = 1'b0;
        count_steps(0, 4 * SD + 30, ps, ns, gb, to);
        checks++;
        if (to || ps != 4 || ns != 0) begin
            errors++;
            $display("FAIL dpad_both: got up=%0d down=%0d timeout=%0b required up=4 down=0", ps, ns, to);
        end
    endtask

    task automatic test_spinner_analog();
        int ps, ns, gb;
        bit to;
        apply_reset();
        ce = 1'b1;
        spin_res = 2'd2;
        btn_left[0] = 1'b1;
        repeat (SD * 3) @(negedge clk_sys);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL spin_busy: got busy=%b required 1", busy[0]);
        end
        btn_left[0] = 1'b0;
        spin_res = 2'd0;
        count_steps(0, 4 * SD + 30, ps, ns, gb, to);
        checks++;
        if (to || ps != 0 || ns != 4) begin
            errors++;
            $display("FAIL spin_left: got up=%0d down=%0d timeout=%0b required up=0 down=4", ps, ns, to);
        end
        analog_x[7:0] = 8'h05;
        repeat (PD) @(negedge clk_sys);
        analog_x[7:0] = 8'h00;
        count_steps(0, 2 * SD + 30, ps, ns, gb, to);
        checks++;
        if (to || ps != 1 || ns != 0) begin
            errors++;
            $display("FAIL analog_05: got up=%0d down=%0d timeout=%0b required up=1 down=0", ps, ns, to);
        end
        analog_x[7:0] = 8'hE0;
        repeat (PD) @(negedge clk_sys);
        analog_x[7:0] = 8'h00;
        count_steps(0, 3 * SD + 30, ps, ns, gb, to);
        checks++;
        if (to || ps != 0 || ns != 2) begin
            errors++;
            $display("FAIL analog_E0: got up=%0d down=%0d timeout=%0b required up=0 down=2", ps, ns, to);
        end
    endtask

    task automatic test_ext();
        apply_reset();
        ce = 1'b1;
        ext_enc[1:0] = 2'b10;
        repeat (2) @(negedge clk_sys);
        checks++;
        if ({ext_active[0], quad[1:0]} !== 3'b111) begin
            errors++;
            $display("FAIL ext_set: got ext/quad=%b after 2 clk required 111", {ext_active[0], quad[1:0]});
        end
        @(negedge clk_sys);
        checks++;
        if (quad[1:0] !== 2'b10) begin
            errors++;
            $display("FAIL ext_pass: got quad=%b after 3 clk required 10", quad[1:0]);
        end
        pulse_delta(0, 9'd0);
        checks++;
        if (ext_active[0] !== 1'b0 || ext_active[1] !== 1'b0) begin
            errors++;
            $display("FAIL ext_clear: got ext=%b required 00", ext_active);
        end
        @(negedge clk_sys);
        checks++;
        if (quad[1:0] !== 2'b11) begin
            errors++;
            $display("FAIL ext_release: got quad=%b required 11", quad[1:0]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ce = 1'b0;
        pulse_delta(0, 9'd100);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got busy=%b required 1", busy[0]);
        end
        ce = 1'b1;
        repeat (SD * 2 + 3) @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({quad[1:0], busy[0]} !== 3'b110) begin
            errors++;
            $display("FAIL mid_reset: got quad/busy=%b required 110", {quad[1:0], busy[0]});
        end
        @(negedge clk_sys);
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            checks++;
            if ({quad[1:0], busy[0], ext_active[0]} !== 4'b1100) begin
                errors++;
                $display("FAIL ch_isolation cycle %0d: got ch0 quad/busy/ext=%b required 1100", i,
                         {quad[1:0], busy[0], ext_active[0]});
            end
            ce = ($urandom_range(0, 3) != 0);
            delta_stb[1] = ($urandom_range(0, 5) == 0);
            delta[17:9] = 9'($urandom);
            if ($urandom_range(0, 15) == 0) btn_left[1] = 1'($urandom);
            if ($urandom_range(0, 15) == 0) btn_right[1] = 1'($urandom);
            btn_fast[1] = 1'($urandom);
            if ($urandom_range(0, 30) == 0) analog_x[15:8] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ext_enc[3:2] = 2'($urandom);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if ({quad[c*2 +: 2], busy[c], ext_active[c]} !== {m_quad[c], m_busy[c], m_ext[c]}) begin
                    errors++;
                    $display("FAIL random cycle %0d ch%0d: got quad/busy/ext=%b required %b", i, c,
                             {quad[c*2 +: 2], busy[c], ext_active[c]}, {m_quad[c], m_busy[c], m_ext[c]});
                end
            end
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) spin_res = 2'($urandom);
            for (int c = 0; c < CH; c++) begin
                delta_stb[c] = ($urandom_range(0, 7) == 0);
                delta[c*9 +: 9] = 9'($urandom);
                if ($urandom_range(0, 29) == 0) btn_left[c] = 1'($urandom);
                if ($urandom_range(0, 29) == 0) btn_right[c] = 1'($urandom);
                if ($urandom_range(0, 29) == 0) btn_fast[c] = 1'($urandom);
                if ($urandom_range(0, 59) == 0)
                    analog_x[c*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
                if ($urandom_range(0, 9) == 0) ext_enc[c*2 +: 2] = 2'($urandom);
            end
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin : main
        test_reset();
        test_delta_steps();
        test_saturation();
        test_dpad();
        test_spinner_analog();
        test_ext();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
